// File: rtl/mem_sequencer_if.sv
// Control bus between the sequencer and the accumulator datapath/memory arbiter.
// master = sequencer side, slave = datapath side.
interface mem_sequencer_if;
  logic [1:0] opcode;
  logic       ext_req;
  logic       en_mem;
  logic       en_ir;
  logic       en_op1;
  logic       en_op2;
  logic       en_io;
  logic       en_pc;
  logic [1:0] sel_mux;
  logic [1:0] sel_oper;
  logic       ext_gnt;

  modport master (
    input  opcode, ext_req,
    output en_mem, en_ir, en_op1, en_op2, en_io, en_pc, sel_mux, sel_oper, ext_gnt
  );

  modport slave (
    output opcode, ext_req,
    input  en_mem, en_ir, en_op1, en_op2, en_io, en_pc, sel_mux, sel_oper, ext_gnt
  );
endinterface

// File: rtl/mem_sequencer.sv
// Moore control sequencer for the 14-bit accumulator datapath with memory-port arbitration.
// Optional single-step mode (PAUSE state, step_i input) enabled by SINGLE_STEP_EN.
module mem_sequencer #(
  parameter int unsigned EXT_MAX = 16,
  parameter int unsigned ICNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
`ifdef SINGLE_STEP_EN
  input  logic              step_i,
`endif
  mem_sequencer_if.master   seq_bus,
  output logic              busy_o,
  output logic              halted_o,
  output logic [ICNT_W-1:0] icount_o
);

  localparam int unsigned TenW = $clog2(EXT_MAX + 1);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StFetchW,
    StDecode,
    StLdA,
    StLdAW,
    StLdB,
    StLdBW,
    StExec,
    StHalt,
    StExt
`ifdef SINGLE_STEP_EN
    , StPause
`endif
  } state_e;

  state_e            state_q, state_d;
  state_e            tgt_q, tgt_d;
  state_e            bnd_tgt;
  logic [TenW-1:0]   ten_q, ten_d;
  logic              fair_q, fair_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;
  logic              bnd;
  logic              fair_eff;

`ifdef SINGLE_STEP_EN
  logic step_q;
  logic step_rise;

  assign step_rise = step_i & ~step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step_i;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tgt_q   <= StIdle;
      ten_q   <= '0;
      fair_q  <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      ten_q   <= ten_d;
      fair_q  <= fair_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    tgt_d            = tgt_q;
    ten_d            = ten_q;
    fair_d           = fair_q;
    icnt_d           = icnt_q;
    bnd              = 1'b0;
    bnd_tgt          = StFetch;
    fair_eff         = fair_q;
    seq_bus.en_mem   = 1'b0;
    seq_bus.en_ir    = 1'b0;
    seq_bus.en_op1   = 1'b0;
    seq_bus.en_op2   = 1'b0;
    seq_bus.en_io    = 1'b0;
    seq_bus.en_pc    = 1'b0;
    seq_bus.sel_mux  = 2'b00;
    seq_bus.sel_oper = 2'b00;
    seq_bus.ext_gnt  = 1'b0;
    halted_o         = 1'b0;
    busy_o           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_i) bnd = 1'b1;
      end
      StFetch: begin
        busy_o  = 1'b1;
        fair_d  = 1'b0;
        state_d = StFetchW;
      end
      StFetchW: begin
        busy_o        = 1'b1;
        seq_bus.en_ir = 1'b1;
        seq_bus.en_pc = 1'b1;
        state_d       = StDecode;
      end
      StDecode: begin
        busy_o = 1'b1;
        if (icnt_q != '1) icnt_d = icnt_q + 1'b1;
        if (seq_bus.opcode == 2'b11) begin
          bnd     = 1'b1;
          bnd_tgt = StHalt;
        end else begin
          state_d = StLdA;
        end
      end
      StLdA: begin
        busy_o          = 1'b1;
        seq_bus.sel_mux = 2'b01;
        state_d         = StLdAW;
      end
      StLdAW: begin
        busy_o          = 1'b1;
        seq_bus.sel_mux = 2'b01;
        if (seq_bus.opcode == 2'b10) begin
          seq_bus.en_io = 1'b1;
          bnd           = 1'b1;
        end else begin
          seq_bus.en_op1 = 1'b1;
          state_d        = StLdB;
        end
      end
      StLdB: begin
        busy_o          = 1'b1;
        seq_bus.sel_mux = 2'b10;
        state_d         = StLdBW;
      end
      StLdBW: begin
        busy_o          = 1'b1;
        seq_bus.sel_mux = 2'b10;
        seq_bus.en_op2  = 1'b1;
        state_d         = StExec;
      end
      StExec: begin
        busy_o           = 1'b1;
        seq_bus.sel_mux  = 2'b11;
        seq_bus.sel_oper = seq_bus.opcode;
        seq_bus.en_mem   = 1'b1;
        bnd              = 1'b1;
      end
      StHalt: begin
        halted_o = 1'b1;
        if (run_i) bnd = 1'b1;
      end
      StExt: begin
        seq_bus.ext_gnt = 1'b1;
        if (!seq_bus.ext_req) begin
          state_d = tgt_q;
          ten_d   = '0;
        end else if (ten_q == TenW'(EXT_MAX - 1)) begin
          // Tenure expired: revoke and block re-grant until an instruction fetches.
          state_d = tgt_q;
          ten_d   = '0;
          fair_d  = 1'b1;
        end else begin
          ten_d = ten_q + 1'b1;
        end
      end
`ifdef SINGLE_STEP_EN
      StPause: begin
        if (seq_bus.ext_req && !fair_q) begin
          state_d = StExt;
          tgt_d   = StPause;
        end else if (step_rise) begin
          state_d = StFetch;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (bnd) begin
`ifdef SINGLE_STEP_EN
      if (bnd_tgt == StFetch) bnd_tgt = StPause;
`endif
      // From IDLE/HALT there is no pending instruction, so fairness does not apply.
      if (state_q == StIdle || state_q == StHalt) begin
        fair_eff = 1'b0;
        fair_d   = 1'b0;
      end
      if (seq_bus.ext_req && !fair_eff) begin
        state_d = StExt;
        tgt_d   = bnd_tgt;
      end else begin
        state_d = bnd_tgt;
      end
    end
  end

  assign icount_o = icnt_q;

endmodule

// File: doc/mem_sequencer.md
Name: mem_sequencer

Overview:
- Multi-cycle control sequencer for the 14-bit accumulator datapath (PC, RI, OP1, OP2, IO registers, ALU, address mux, shared memory).
- Generates every register enable, the address-mux select and the ALU operation select.
- Arbitrates the single memory port between the CPU datapath and an external loader/debug requester. The grant is given only at instruction boundaries, and a tenure limit bounds how long the loader can hold the port.

Parameters:
- EXT_MAX, 16: max consecutive cycles the external requester may hold the memory grant (≥1).
- ICNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- run  in  1  level; start execution from IDLE, resume from HALT.
- opcode  in  2  RI[13:12]; 00 ADD, 01 SUB, 10 OUT, 11 HALT.
- ext_req  in  1  external memory request, level, held until done.
- en_mem  out  1  memory write enable.
- en_ir  out  1  RI load.
- en_op1  out  1  OP1 load.
- en_op2  out  1  OP2 load.
- en_io  out  1  IO/output register load.
- en_pc  out  1  PC increment.
- sel_mux  out  2  address select: 00 PC, 01 RI[11:8], 10 RI[7:4], 11 RI[3:0].
- sel_oper  out  2  ALU op: 00 add, 01 sub.
- ext_gnt  out  1  memory port owned by external requester; top level routes ext address/data.
- busy  out  1  high in any CPU execution state.
- halted  out  1  high in HALT.
- icount  out  ICNT_W  retired-instruction count.

Behaviour:
- Moore FSM; all outputs are decoded from registered state.
- Memory has a registered read: data is valid one cycle after the address is presented.
- Reset values: state IDLE, all enables 0, sel_mux 00, sel_oper 00, ext_gnt 0, busy 0, halted 0, icount 0, tenure counter 0, fairness flag 0.
- Per-state outputs and transitions (any enable not listed is 0):
  - IDLE: no enables. If run=1 → boundary check with target FETCH.
  - FETCH: sel_mux 00 → FETCH_W.
  - FETCH_W: sel_mux 00, en_ir=1, en_pc=1 → DECODE.
  - DECODE: icount += 1, saturating at all-ones. opcode 11 → boundary check with target HALT; otherwise → LD_A.
  - LD_A: sel_mux 01 → LD_A_W.
  - LD_A_W: sel_mux 01. OUT: en_io=1 → boundary check with target FETCH. ADD/SUB: en_op1=1 → LD_B.
  - LD_B: sel_mux 10 → LD_B_W.
  - LD_B_W: sel_mux 10, en_op2=1 → EXEC.
  - EXEC: sel_mux 11, sel_oper=opcode, en_mem=1 → boundary check with target FETCH.
  - HALT: halted=1. If run=1 → boundary check with target FETCH. The PC has already advanced past the HALT instruction.
  - EXT: ext_gnt=1, all CPU enables 0, busy 0.
- Boundary check, evaluated in the cycle the transition is taken:
  - If ext_req=1 and fairness flag=0 → EXT, saving the target (FETCH, HALT or IDLE-resume).
  - Otherwise → target.
  - The fairness flag clears whenever a FETCH is entered.
- EXT tenure:
  - The tenure counter increments every EXT cycle.
  - On ext_req=0 → saved target, counter cleared.
  - On reaching EXT_MAX cycles with ext_req still 1 → grant is revoked, fairness flag set, FSM → saved target. The requester cannot win again until one full instruction has fetched.
  - Exception: if the saved target is HALT or IDLE, there is no instruction to wait for, so the flag clears on the next boundary check.
- Instruction latency: ADD/SUB 8 cycles, OUT 5 cycles, HALT 3 cycles, each from FETCH entry to the next boundary.
- Async reset at any time, including mid-EXT or mid-EXEC, forces the reset values immediately; ext_gnt drops without waiting for a clock.
- run is ignored in every state except IDLE and HALT.
- opcode is sampled only in DECODE, LD_A_W and EXEC. RI is stable there.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - Adds state PAUSE, taken after the boundary check whenever the target is FETCH. busy=0 in PAUSE.
  - A rising edge of step (edge-detected internally) → FETCH.
  - ext_req in PAUSE is granted as in a boundary check, returning to PAUSE afterwards.
- Undefined: no step port, no PAUSE state; execution is free-running.

Test Plan:
- Program load: mem[0]=14'h089A (ADD 8,9→10), mem[1]=14'h2A00 (OUT 10), mem[2]=14'h3000 (HALT), mem[8]=3, mem[9]=4; pulse run → Outp=7, halted=1 at cycle 16 after FETCH entry, icount=3.
- SUB: mem[0]=14'h189A, mem[8]=9, mem[9]=4 → mem[10]=5 after EXEC; sel_oper=01 only in EXEC.
- Arbitration: ext_req raised during LD_B of an ADD → ext_gnt=0 until EXEC completes, then ext_gnt=1 next cycle; drop ext_req → FETCH next cycle, PC continues.
- Tenure: EXT_MAX=4, ext_req held high → ext_gnt high exactly 4 cycles, then one full instruction executes, then ext_gnt reasserts.
- Reset mid-EXT and mid-EXEC: rst_n low → all outputs 0 immediately, including ext_gnt; state IDLE; icount=0.
- SINGLE_STEP_EN: run=1 → FSM parks in PAUSE after each instruction; each step edge retires exactly one instruction (icount +1); step held high retires only one.
